// File: rtl/pool_frame_sequencer.sv
// Frame controller: streams a stored frame into the pooling block and collects its results.
// Optional drain watchdog enabled by defining POOL_SEQ_TIMEOUT_EN.
module pool_frame_sequencer #(
    parameter int IMG_W         = 1242,
    parameter int IMG_H         = 375,
    parameter int OUT_W         = 26,
    parameter int OUT_H         = 8,
    parameter int PIX_W         = 8,
    parameter int ADDR_W        = 19,
    parameter int RES_AW        = 8,
    parameter int DRAIN_TIMEOUT = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic              pool_new_frame,
    output logic [PIX_W-1:0]  pool_pixel,
    output logic              pool_valid,
    input  logic [PIX_W-1:0]  pool_result,
    input  logic              pool_result_valid,
    output logic              res_we,
    output logic [RES_AW-1:0] res_addr,
    output logic [PIX_W-1:0]  res_data
);
    localparam int N    = IMG_W * IMG_H;
    localparam int M    = OUT_W * OUT_H;
    localparam int RC_W = RES_AW + 1;

    if ((64'd1 << ADDR_W) < 64'(N) || (64'd1 << RES_AW) < 64'(M) || DRAIN_TIMEOUT < 1)
    begin : g_param_check
        $error("pool_frame_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEWF,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [RC_W-1:0]   res_cnt;
    logic              overflow_flag;
    logic              timeout_flag;
    logic              drain_timeout_hit;
    logic              capture_active;
    logic              res_room;
    logic              drain_complete;

    assign capture_active = (state == S_NEWF) || (state == S_FEED) || (state == S_DRAIN);
    assign res_room       = res_cnt < RC_W'(M);
    assign drain_complete = (res_cnt == RC_W'(M)) && !pool_valid;

    // Read strobe and result writes are combinational so a pause or a result lands in its own cycle.
    assign src_rd     = (state == S_FEED) && !pause;
    assign src_addr   = addr_cnt;
    assign res_we     = capture_active && pool_result_valid && res_room;
    assign res_addr   = res_cnt[RES_AW-1:0];
    assign res_data   = res_we ? pool_result : '0;
    assign pool_pixel = pool_valid ? src_data : '0;
    assign status     = {overflow_flag, timeout_flag};

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            addr_cnt       <= '0;
            res_cnt        <= '0;
            overflow_flag  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pool_new_frame <= 1'b0;
            pool_valid     <= 1'b0;
        end else begin
            pool_valid <= src_rd;
            if (res_we) begin
                res_cnt <= res_cnt + 1'b1;
            end
            if (capture_active && pool_result_valid && !res_room) begin
                overflow_flag <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_NEWF;
                        busy           <= 1'b1;
                        pool_new_frame <= 1'b1;
                        overflow_flag  <= 1'b0;
                        addr_cnt       <= '0;
                        res_cnt        <= '0;
                    end
                end
                S_NEWF: begin
                    pool_new_frame <= 1'b0;
                    state          <= S_FEED;
                end
                S_FEED: begin
                    // The counter parks on the last address instead of wrapping.
                    if (src_rd) begin
                        if (addr_cnt == ADDR_W'(N - 1)) begin
                            state <= S_DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_complete || drain_timeout_hit) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POOL_SEQ_TIMEOUT_EN
    localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [DT_W-1:0] drain_cnt;

    // Only a short drain can abort; a full result set always exits through drain_complete.
    assign drain_timeout_hit = (state == S_DRAIN) && res_room &&
                               (drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if (state == S_IDLE && start) begin
                timeout_flag <= 1'b0;
            end else if (drain_timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign drain_timeout_hit = 1'b0;
    assign timeout_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// Directed bench for pool_frame_sequencer on a small 8x4 -> 2x2 frame.
// The source memory and pooling-block results are driven from the test tasks.
module tb_pool_frame_sequencer;
    localparam int IMG_W = 8, IMG_H = 4, OUT_W = 2, OUT_H = 2;
    localparam int PIX_W = 8, ADDR_W = 19, RES_AW = 8, DRAIN_TIMEOUT = 20;
    localparam int N = IMG_W * IMG_H;
    localparam int M = OUT_W * OUT_H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              busy, done;
    logic [1:0]        status;
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [PIX_W-1:0]  src_data = '0;
    logic              pool_new_frame;
    logic [PIX_W-1:0]  pool_pixel;
    logic              pool_valid;
    logic [PIX_W-1:0]  pool_result = '0;
    logic              pool_result_valid = 1'b0;
    logic              res_we;
    logic [RES_AW-1:0] res_addr;
    logic [PIX_W-1:0]  res_data;

    pool_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H), .PIX_W(PIX_W),
        .ADDR_W(ADDR_W), .RES_AW(RES_AW), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .busy(busy), .done(done),
        .status(status), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .pool_new_frame(pool_new_frame), .pool_pixel(pool_pixel), .pool_valid(pool_valid),
        .pool_result(pool_result), .pool_result_valid(pool_result_valid),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 3) ^ 8'h5A;
    endfunction

    // Event recorder, sampled on the falling edge.
    int                cyc = 0, rd_cnt = 0, pix_cnt = 0, wr_cnt = 0;
    int                done_cnt = 0, nf_cnt = 0, pv_bad = 0, busy_at_done = 0;
    int                done_cyc = 0, nf_cyc = 0;
    logic              prev_rd = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] addr_log [0:1023];
    int                rd_cyc_log [0:1023];
    logic [7:0]        pix_log [0:1023];
    int                pv_cyc_log [0:1023];
    logic [7:0]        wa_log [0:1023];
    logic [7:0]        wd_log [0:1023];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (src_rd === 1'b1) begin
            addr_log[rd_cnt % 1024]   <= src_addr;
            rd_cyc_log[rd_cnt % 1024] <= cyc + 1;
            rd_cnt                    <= rd_cnt + 1;
            last_addr                 <= src_addr;
        end
        if (pool_valid === 1'b1) begin
            pix_log[pix_cnt % 1024]    <= pool_pixel;
            pv_cyc_log[pix_cnt % 1024] <= cyc + 1;
            pix_cnt                    <= pix_cnt + 1;
        end
        if (rst_n && pool_valid !== prev_rd) pv_bad <= pv_bad + 1;
        prev_rd <= src_rd & rst_n;
        if (res_we === 1'b1) begin
            wa_log[wr_cnt % 1024] <= res_addr;
            wd_log[wr_cnt % 1024] <= res_data;
            wr_cnt                <= wr_cnt + 1;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc + 1;
            if (busy !== 1'b0) busy_at_done <= busy_at_done + 1;
        end
        if (pool_new_frame === 1'b1) begin
            nf_cnt <= nf_cnt + 1;
            nf_cyc <= cyc + 1;
        end
    end

    // Per-frame measurements filled in by run_frame.
    int f_rd0, f_pv0, f_wr0, f_done0, f_nf0, f_start_cyc;
    int f_rd_n, f_pix_n, f_wr_n, f_addr_bad, f_pix_bad, f_wr_bad;
    bit f_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int gap, input int n_res, input int pause_at,
                             input int pause_len, input int extra_at, input int budget);
        int  sent, pleft, n, thr;
        bit  xdone;
        f_rd0 = rd_cnt; f_pv0 = pix_cnt; f_wr0 = wr_cnt; f_done0 = done_cnt; f_nf0 = nf_cnt;
        f_start_cyc = cyc + 1;
        start = 1'b1; pause = 1'b0; pool_result_valid = 1'b0;
        step();
        sent = 0; pleft = pause_len; n = 0; xdone = 1'b0;
        while (done_cnt == f_done0 && n < budget) begin
            start = 1'b0; pause = 1'b0; pool_result_valid = 1'b0; pool_result = '0;
            src_data = pat(int'(last_addr));
            if (pleft > 0 && rd_cnt - f_rd0 == pause_at + 1) begin
                pause = 1'b1;
                pleft--;
            end
            thr = gap * (sent + 1);
            if (thr > N) thr = N;
            if (sent < n_res && pix_cnt - f_pv0 >= thr) begin
                pool_result_valid = 1'b1;
                pool_result = 8'(8'hA0 + sent);
                sent++;
            end
            if (extra_at >= 0 && !xdone && rd_cnt - f_rd0 == extra_at) begin
                start = 1'b1;
                xdone = 1'b1;
            end
            step();
            n++;
        end
        start = 1'b0; pause = 1'b0; pool_result_valid = 1'b0;
        f_done  = (done_cnt != f_done0);
        f_rd_n  = rd_cnt - f_rd0;
        f_pix_n = pix_cnt - f_pv0;
        f_wr_n  = wr_cnt - f_wr0;
        f_addr_bad = 0; f_pix_bad = 0; f_wr_bad = 0;
        for (int i = 0; i < f_rd_n; i++)
            if (addr_log[(f_rd0 + i) % 1024] !== ADDR_W'(i)) f_addr_bad++;
        for (int i = 0; i < f_pix_n; i++)
            if (pix_log[(f_pv0 + i) % 1024] !== pat(i)) f_pix_bad++;
        for (int j = 0; j < f_wr_n; j++)
            if (wa_log[(f_wr0 + j) % 1024] !== 8'(j) || wd_log[(f_wr0 + j) % 1024] !== 8'(8'hA0 + j))
                f_wr_bad++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [50:0] all_outputs();
        return {busy, done, status, src_rd, src_addr, pool_new_frame, pool_pixel,
                pool_valid, res_we, res_addr, res_data};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        step(); rst_n = 1'b1; step();
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL idle_outputs: got %h expected 0", all_outputs());
        end
    endtask

    task automatic test_nominal();
        run_frame(8, 4, 0, 0, -1, 200);
        checks++;
        if (f_done !== 1'b1) begin errors++; $display("FAIL nom_done: got %0d expected 1", f_done); end
        checks++;
        if (nf_cyc !== f_start_cyc + 1) begin
            errors++; $display("FAIL nom_new_frame_cycle: got %0d expected %0d", nf_cyc, f_start_cyc + 1);
        end
        checks++;
        if (rd_cyc_log[f_rd0 % 1024] !== f_start_cyc + 2) begin
            errors++; $display("FAIL nom_first_rd_cycle: got %0d expected %0d", rd_cyc_log[f_rd0 % 1024], f_start_cyc + 2);
        end
        checks++;
        if (f_rd_n !== N) begin errors++; $display("FAIL nom_rd_count: got %0d expected %0d", f_rd_n, N); end
        checks++;
        if (rd_cyc_log[(f_rd0 + N - 1) % 1024] - rd_cyc_log[f_rd0 % 1024] !== N - 1) begin
            errors++; $display("FAIL nom_rd_span: got %0d expected %0d",
                               rd_cyc_log[(f_rd0 + N - 1) % 1024] - rd_cyc_log[f_rd0 % 1024], N - 1);
        end
        checks++;
        if (f_addr_bad !== 0) begin errors++; $display("FAIL nom_addr_seq: got %0d bad expected 0", f_addr_bad); end
        checks++;
        if (f_pix_n !== N || f_pix_bad !== 0) begin
            errors++; $display("FAIL nom_pixels: got %0d pixels %0d bad expected %0d pixels 0 bad", f_pix_n, f_pix_bad, N);
        end
        checks++;
        if (pv_bad !== 0) begin errors++; $display("FAIL nom_valid_latency: got %0d bad expected 0", pv_bad); end
        checks++;
        if (f_wr_n !== M || f_wr_bad !== 0) begin
            errors++; $display("FAIL nom_writes: got %0d writes %0d bad expected %0d writes 0 bad", f_wr_n, f_wr_bad, M);
        end
        checks++;
        if (done_cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024] !== 3) begin
            errors++; $display("FAIL nom_done_latency: got %0d expected 3", done_cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024]);
        end
        checks++;
        if (status !== 2'b00) begin errors++; $display("FAIL nom_status: got %b expected 00", status); end
        step();
        checks++;
        if (done_cnt - f_done0 !== 1 || busy_at_done !== 0) begin
            errors++; $display("FAIL nom_done_pulse: got %0d pulses busy_bad=%0d expected 1 pulses busy_bad=0",
                               done_cnt - f_done0, busy_at_done);
        end
        idle(3);
    endtask

    task automatic test_pause();
        run_frame(8, 4, 10, 5, -1, 200);
        checks++;
        if (f_done !== 1'b1 || f_rd_n !== N || f_addr_bad !== 0) begin
            errors++; $display("FAIL pause_reads: got done=%0d reads=%0d bad=%0d expected done=1 reads=%0d bad=0",
                               f_done, f_rd_n, f_addr_bad, N);
        end
        checks++;
        if (rd_cyc_log[(f_rd0 + 11) % 1024] - rd_cyc_log[(f_rd0 + 10) % 1024] !== 6) begin
            errors++; $display("FAIL pause_gap: got %0d expected 6",
                               rd_cyc_log[(f_rd0 + 11) % 1024] - rd_cyc_log[(f_rd0 + 10) % 1024]);
        end
        checks++;
        if (rd_cyc_log[(f_rd0 + N - 1) % 1024] - rd_cyc_log[f_rd0 % 1024] !== N - 1 + 5) begin
            errors++; $display("FAIL pause_span: got %0d expected %0d",
                               rd_cyc_log[(f_rd0 + N - 1) % 1024] - rd_cyc_log[f_rd0 % 1024], N + 4);
        end
        checks++;
        if (f_pix_n !== N || f_pix_bad !== 0) begin
            errors++; $display("FAIL pause_pixels: got %0d pixels %0d bad expected %0d pixels 0 bad", f_pix_n, f_pix_bad, N);
        end
        idle(3);
    endtask

    task automatic test_overflow();
        run_frame(8, 5, 0, 0, -1, 200);
        checks++;
        if (f_done !== 1'b1 || f_wr_n !== M || f_wr_bad !== 0) begin
            errors++; $display("FAIL ovf_writes: got done=%0d writes=%0d bad=%0d expected done=1 writes=%0d bad=0",
                               f_done, f_wr_n, f_wr_bad, M);
        end
        checks++;
        if (status !== 2'b10) begin errors++; $display("FAIL ovf_status: got %b expected 10", status); end
        idle(3);
    endtask

    task automatic test_timeout();
`ifdef POOL_SEQ_TIMEOUT_EN
        run_frame(8, 2, 0, 0, -1, 200);
        checks++;
        if (f_done !== 1'b1 || done_cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024] !== DRAIN_TIMEOUT) begin
            errors++; $display("FAIL tmo_done: got done=%0d latency=%0d expected done=1 latency=%0d",
                               f_done, done_cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024], DRAIN_TIMEOUT);
        end
        checks++;
        if (status !== 2'b01) begin errors++; $display("FAIL tmo_status: got %b expected 01", status); end
        checks++;
        if (f_wr_n !== 2 || f_wr_bad !== 0) begin
            errors++; $display("FAIL tmo_writes: got %0d writes %0d bad expected 2 writes 0 bad", f_wr_n, f_wr_bad);
        end
        idle(3);
`else
        run_frame(8, 2, 0, 0, -1, 250);
        checks++;
        if (f_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tmo_hang: got done=%0d busy=%0d expected done=0 busy=1", f_done, busy);
        end
        checks++;
        if (cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024] < 200) begin
            errors++; $display("FAIL tmo_drain_len: got %0d expected >=200", cyc - pv_cyc_log[(f_pv0 + N - 1) % 1024]);
        end
        checks++;
        if (f_wr_n !== 2 || f_wr_bad !== 0) begin
            errors++; $display("FAIL tmo_writes: got %0d writes %0d bad expected 2 writes 0 bad", f_wr_n, f_wr_bad);
        end
        checks++;
        if (status !== 2'b00) begin errors++; $display("FAIL tmo_status: got %b expected 00", status); end
        rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(2);
`endif
    endtask

    task automatic test_reset_mid_feed();
        int base_rd, base_done, n;
        base_rd = rd_cnt; base_done = done_cnt; n = 0;
        start = 1'b1; step(); start = 1'b0;
        while (rd_cnt - base_rd < 15 && n < 100) begin step(); n++; end
        checks++;
        if (src_rd !== 1'b1 || src_addr !== ADDR_W'(15)) begin
            errors++; $display("FAIL mid_pre_reset: got rd=%0d addr=%0d expected rd=1 addr=15", src_rd, src_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outputs());
        end
        idle(2); rst_n = 1'b1; idle(3);
        checks++;
        if (done_cnt !== base_done) begin
            errors++; $display("FAIL mid_no_done: got %0d expected %0d", done_cnt, base_done);
        end
        run_frame(8, 4, 0, 0, -1, 200);
        checks++;
        if (f_done !== 1'b1 || f_rd_n !== N || f_addr_bad !== 0 || f_wr_n !== M) begin
            errors++; $display("FAIL mid_restart: got done=%0d reads=%0d bad=%0d writes=%0d expected 1 %0d 0 %0d",
                               f_done, f_rd_n, f_addr_bad, f_wr_n, N, M);
        end
        idle(3);
    endtask

    task automatic test_start_while_busy();
        run_frame(2, 5, 0, 0, 20, 200);
        checks++;
        if (status !== 2'b10) begin errors++; $display("FAIL busy_start_status: got %b expected 10", status); end
        checks++;
        if (nf_cnt - f_nf0 !== 1 || f_rd_n !== N || f_addr_bad !== 0) begin
            errors++; $display("FAIL busy_start_ignored: got frames=%0d reads=%0d bad=%0d expected 1 %0d 0",
                               nf_cnt - f_nf0, f_rd_n, f_addr_bad, N);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        run_frame(8, 5, 0, 0, -1, 200);
        checks++;
        if (f_done !== 1'b1 || status !== 2'b10) begin
            errors++; $display("FAIL b2b_first: got done=%0d status=%b expected done=1 status=10", f_done, status);
        end
        run_frame(8, 4, 0, 0, -1, 200);
        checks++;
        if (nf_cyc !== f_start_cyc + 1 || f_done !== 1'b1) begin
            errors++; $display("FAIL b2b_second_start: got nf=%0d done=%0d expected nf=%0d done=1",
                               nf_cyc, f_done, f_start_cyc + 1);
        end
        checks++;
        if (status !== 2'b00 || f_rd_n !== N || f_wr_n !== M) begin
            errors++; $display("FAIL b2b_second_frame: got status=%b reads=%0d writes=%0d expected 00 %0d %0d",
                               status, f_rd_n, f_wr_n, N, M);
        end
        idle(3);
        checks++;
        if (pv_bad !== 0) begin errors++; $display("FAIL valid_latency_total: got %0d bad expected 0", pv_bad); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no summary before time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_pause();
        test_overflow();
        test_timeout();
        test_reset_mid_feed();
        test_start_while_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
